raster_scheduler: RTL
=====================

Name: raster_scheduler

Overview:
- Frame-level controller for the rasterizer; sits between the triangle source (geometry/CPU side) and the rasterizer.
- Per frame it clears the back buffer, then dispatches queued triangles to the rasterizer one at a time using start/done.
- On the frame's last triangle it swaps front/back buffer select and pulses frame done.
- Decouples the triangle producer from rasterizer latency with a small internal queue.

Parameters:
- COORD_WIDTH, 16: bits per vertex coordinate.
- QUEUE_DEPTH, 8: triangle queue entries; power of two, ≥2.
- H_RES, 320: clear sweep width in pixels.
- V_RES, 240: clear sweep height in pixels.
- CNT_WIDTH, 16: width of triangle counter.

Ports:
- clk_in  in  1  system clock; single clock domain.
- rst_in  in  1  asynchronous, active-low reset.
- frame_start_in  in  1  one-cycle frame trigger (vsync-derived).
- tri_valid_in  in  1  triangle push request.
- tri_ready_out  out  1  queue can accept; equals not-full.
- tri_in  in  6*COORD_WIDTH  {x0,y0,x1,y1,x2,y2}, x0 in MSBs.
- tri_last_in  in  1  marks last triangle of frame.
- rast_start_out  out  1  one-cycle start to rasterizer.
- rast_tri_out  out  6*COORD_WIDTH  registered vertices for the current job.
- rast_busy_in  in  1  rasterizer busy.
- rast_done_in  in  1  rasterizer done pulse.
- clear_valid_out  out  1  clear-pixel write strobe.
- clear_x_out  out  COORD_WIDTH  clear pixel x.
- clear_y_out  out  COORD_WIDTH  clear pixel y.
- buf_sel_out  out  1  front buffer index; back buffer = ~buf_sel_out.
- frame_done_out  out  1  one-cycle pulse at swap.
- busy_out  out  1  high in any state except IDLE.
- tri_count_out  out  CNT_WIDTH  triangles completed this frame; saturates.
- overrun_out  out  1  sticky; set by a frame start not accepted.

Behaviour:
- Reset (rst_in low, asynchronous):
  - all outputs 0, including buf_sel_out;
  - queue empty, state IDLE;
  - takes effect immediately, including mid-frame.
- Queue:
  - push when tri_valid_in && tri_ready_out; stores {tri_in, tri_last_in};
  - pop only in FETCH;
  - push is accepted in any state, including IDLE between frames;
  - push when full is dropped (ready is low);
  - simultaneous push and pop while full: push is still refused, because ready derives from full only.
- IDLE:
  - frame_start_in → CLEAR;
  - tri_count_out cleared to 0 on that edge.
- CLEAR:
  - one pixel per cycle, clear_valid_out=1;
  - x runs 0..H_RES-1 fastest, then y runs 0..V_RES-1;
  - exactly H_RES*V_RES strobes;
  - after the strobe at (H_RES-1, V_RES-1) → FETCH, with clear outputs 0 next cycle.
- FETCH:
  - if the queue is non-empty: pop, register into rast_tri_out and a last flag → LAUNCH;
  - otherwise stall in FETCH.
- LAUNCH:
  - if !rast_busy_in: assert rast_start_out for exactly one cycle → WAIT;
  - otherwise hold, start low.
  - First start therefore occurs 2 cycles after FETCH is entered with a non-empty queue.
- WAIT:
  - on rast_done_in: tri_count_out+1, saturating at all-ones;
  - then → SWAP if the last flag is set, else → FETCH.
  - rast_done_in is ignored in every state other than WAIT.
- SWAP (1 cycle):
  - buf_sel_out toggles;
  - frame_done_out=1;
  - → IDLE.
- frame_start_in in any non-IDLE state, SWAP included: ignored, overrun_out←1. overrun_out stays set until reset.
- rast_tri_out holds its value between jobs; it is not cleared at frame end.
- The rasterizer is never started during CLEAR.

Decomposition:
- Shared package raster_pkg holds:
  - state enum sched_state_t {IDLE, CLEAR, FETCH, LAUNCH, WAIT, SWAP};
  - tri_t packed struct of six COORD_WIDTH coordinates, with the packing order above;
  - default H_RES/V_RES constants.
- One sub-module: tri_fifo, a synchronous FIFO with async active-low reset and parameters WIDTH, DEPTH.
  - outputs full/empty;
  - first-word-fall-through read data.
- Scheduler FSM, clear counters and triangle counter live in raster_scheduler.

Test Plan:
- Basic frame (bench uses H_RES=4, V_RES=2):
  - stimulus: reset; push tri A and tri B (last); pulse frame_start_in;
  - response: 8 clear strobes, (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1); two rast_start_out pulses carrying A then B; frame_done_out one cycle; buf_sel_out 0→1; tri_count_out=2.
- Full queue:
  - stimulus: 9 pushes with no frame running;
  - response: tri_ready_out low after the 8th; 9th not stored; a subsequent frame launches exactly 8 jobs.
- Overrun:
  - stimulus: frame_start_in pulsed while in WAIT;
  - response: overrun_out=1 and stays 1; state, tri_count_out and buf_sel_out unaffected; second frame not started.
- Starved queue:
  - stimulus: frame started with empty queue; push last tri 20 cycles after CLEAR ends;
  - response: rast_start_out stays low during the gap; start pulses 2 cycles after the push is accepted; frame completes.
- Busy hold-off:
  - stimulus: rast_busy_in held high for 5 cycles at LAUNCH;
  - response: rast_start_out low for those 5 cycles; a single start pulse in the cycle after busy drops.
- Reset mid-frame:
  - stimulus: rst_in driven low during WAIT with 3 tris queued;
  - response: all outputs 0 immediately, without waiting for a clock edge; queue empty (tri_ready_out=0 during reset, 1 after release); next frame clears and stalls in FETCH.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared types and defaults for the raster frame scheduler and its triangle queue.
package raster_pkg;

    localparam int DEF_COORD_WIDTH = 16;
    localparam int DEF_H_RES       = 320;
    localparam int DEF_V_RES       = 240;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        LAUNCH,
        WAIT,
        SWAP
    } sched_state_t;

    // Vertex order on the wire: x0 occupies the MSBs, y2 the LSBs.
    typedef struct packed {
        logic [DEF_COORD_WIDTH-1:0] x0;
        logic [DEF_COORD_WIDTH-1:0] y0;
        logic [DEF_COORD_WIDTH-1:0] x1;
        logic [DEF_COORD_WIDTH-1:0] y1;
        logic [DEF_COORD_WIDTH-1:0] x2;
        logic [DEF_COORD_WIDTH-1:0] y2;
    } tri_t;

endpackage

// File: rtl/tri_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data shows the head entry whenever empty is low.
module tri_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/raster_scheduler.sv
// Frame controller: clears the back buffer, feeds queued triangles to the rasterizer one at a
// time, then swaps buffers. Handshake: a triangle is taken on any edge where tri_valid_in and
// tri_ready_out are both high; ready depends only on queue fullness, never on valid.
module raster_scheduler
    import raster_pkg::*;
#(
    parameter int COORD_WIDTH = DEF_COORD_WIDTH,
    parameter int QUEUE_DEPTH = 8,
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     frame_start_in,
    input  logic                     tri_valid_in,
    output logic                     tri_ready_out,
    input  logic [6*COORD_WIDTH-1:0] tri_in,
    input  logic                     tri_last_in,
    output logic                     rast_start_out,
    output logic [6*COORD_WIDTH-1:0] rast_tri_out,
    input  logic                     rast_busy_in,
    input  logic                     rast_done_in,
    output logic                     clear_valid_out,
    output logic [COORD_WIDTH-1:0]   clear_x_out,
    output logic [COORD_WIDTH-1:0]   clear_y_out,
    output logic                     buf_sel_out,
    output logic                     frame_done_out,
    output logic                     busy_out,
    output logic [CNT_WIDTH-1:0]     tri_count_out,
    output logic                     overrun_out
);

    localparam int TRI_W = 6*COORD_WIDTH;
    localparam logic [COORD_WIDTH-1:0] X_LAST  = COORD_WIDTH'(H_RES-1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST  = COORD_WIDTH'(V_RES-1);
    localparam logic [COORD_WIDTH-1:0] C_ONE   = COORD_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE = CNT_WIDTH'(1);

    sched_state_t state_q;
    sched_state_t state_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             fifo_push;
    logic [TRI_W:0]   fifo_rd;
    logic             clear_done;
    logic             start_d;
    logic             start_q;
    logic             last_q;
    logic             buf_q;
    logic             overrun_q;
    logic [TRI_W-1:0]       rast_tri_q;
    logic [COORD_WIDTH-1:0] x_q;
    logic [COORD_WIDTH-1:0] y_q;
    logic [CNT_WIDTH-1:0]   count_q;

    // Gating with rst_in keeps ready low while reset is held.
    assign tri_ready_out = rst_in && !fifo_full;
    assign fifo_push     = tri_valid_in && tri_ready_out;

    tri_fifo #(
        .WIDTH(TRI_W + 1),
        .DEPTH(QUEUE_DEPTH)
    ) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({tri_in, tri_last_in}),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign clear_done = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        start_d  = 1'b0;
        case (state_q)
            IDLE:   if (frame_start_in) state_d = CLEAR;
            CLEAR:  if (clear_done) state_d = FETCH;
            FETCH: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!rast_busy_in) begin
                    start_d = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT:   if (rast_done_in) state_d = last_q ? SWAP : FETCH;
            SWAP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            x_q        <= '0;
            y_q        <= '0;
            rast_tri_q <= '0;
            last_q     <= 1'b0;
            start_q    <= 1'b0;
            buf_q      <= 1'b0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            start_q <= start_d;
            if (frame_start_in && state_q == IDLE) begin
                count_q <= '0;
                x_q     <= '0;
                y_q     <= '0;
            end
            if (frame_start_in && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
            // The sweep wraps both counters to zero after the last pixel.
            if (state_q == CLEAR) begin
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_LAST) ? '0 : y_q + C_ONE;
                end else begin
                    x_q <= x_q + C_ONE;
                end
            end
            if (fifo_pop) begin
                rast_tri_q <= fifo_rd[TRI_W:1];
                last_q     <= fifo_rd[0];
            end
            if (state_q == WAIT && rast_done_in) begin
                if (count_q != '1) begin
                    count_q <= count_q + CNT_ONE;
                end
                if (last_q) begin
                    buf_q <= ~buf_q;
                end
            end
        end
    end

    assign rast_start_out  = start_q;
    assign rast_tri_out    = rast_tri_q;
    assign clear_valid_out = (state_q == CLEAR);
    assign clear_x_out     = x_q;
    assign clear_y_out     = y_q;
    assign buf_sel_out     = buf_q;
    assign frame_done_out  = (state_q == SWAP);
    assign busy_out        = (state_q != IDLE);
    assign tri_count_out   = count_q;
    assign overrun_out     = overrun_q;

endmodule
